// File: rtl/cfg_loader_if.sv
// cfg_loader_if: memory-controller read port between cfg_loader (master) and DDR (slave)
//   rd_req_valid/rd_req_ready : read-request handshake
//   rd_req_addr               : byte address of the slot's first beat
//   rd_req_len                : beats requested minus one
//   rd_data_valid/rd_data_ready : read-data handshake
//   rd_data                   : one read-data beat
interface cfg_loader_if #(
    parameter int PORT_DATAWIDTH = 64,
    parameter int ADDR_WIDTH     = 32
);
    logic                      rd_req_valid;
    logic                      rd_req_ready;
    logic [ADDR_WIDTH-1:0]     rd_req_addr;
    logic [7:0]                rd_req_len;
    logic                      rd_data_valid;
    logic                      rd_data_ready;
    logic [PORT_DATAWIDTH-1:0] rd_data;
    modport master (
        output rd_req_valid, rd_req_addr, rd_req_len, rd_data_ready,
        input  rd_req_ready, rd_data_valid, rd_data
    );
    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_len, rd_data_ready,
        output rd_req_ready, rd_data_valid, rd_data
    );
endinterface

// File: rtl/cfg_loader.sv
// cfg_loader: fetches per-layer config slots from DDR, assembles and holds them per layer
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   i_start           : pulse, begin fetching at layer 0 (IDLE only)
//   i_layer_done      : pulse, current layer finished (VALID only)
//   bus               : read-request / read-data port (master side)
//   o_cfg_valid       : o_cfg_word valid for the current layer
//   o_cfg_word        : assembled config word
//   o_cfg_stride      : o_cfg_word[2:0]
//   o_cfg_num_lay     : layer count minus one, from layer-0 word bits [56:49]
//   o_cfg_layer_idx   : index of the current layer
//   o_all_done        : pulse after the final layer_done
//   o_cfg_err         : sticky sanity-check failure
// Optional: define CFG_LOADER_CHECK_EN to check stride (1..4) and non-zero word;
// a failing word parks the loader in ERR until reset.
module cfg_loader #(
    parameter int                    PORT_DATAWIDTH = 64,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    CFG_WIDTH      = 82,
    parameter int                    CFG_BEATS      = 2,
    parameter logic [ADDR_WIDTH-1:0] CFG_BASE       = 32'h0000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_layer_done,
    cfg_loader_if.master         bus,
    output logic                 o_cfg_valid,
    output logic [CFG_WIDTH-1:0] o_cfg_word,
    output logic [2:0]           o_cfg_stride,
    output logic [7:0]           o_cfg_num_lay,
    output logic [7:0]           o_cfg_layer_idx,
    output logic                 o_all_done,
    output logic                 o_cfg_err
);
    localparam int BW = CFG_BEATS > 1 ? $clog2(CFG_BEATS) : 1;
`ifdef CFG_LOADER_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_VALID, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_VALID} state_t;
`endif
    state_t               r_state, w_next;
    logic [7:0]           r_layer_idx, r_num_lay;
    logic [BW-1:0]        r_beat;
    logic [CFG_WIDTH-1:0] r_word, w_word;
    logic                 r_all_done;
    logic                 w_beat_acc, w_last, w_ok, w_adv, w_done_last;
    assign w_beat_acc  = r_state == S_RECV && bus.rd_data_valid;
    assign w_last      = w_beat_acc && r_beat == BW'(CFG_BEATS - 1);
    assign w_adv       = r_state == S_VALID && i_layer_done;
    assign w_done_last = r_layer_idx == r_num_lay;
    // Beat k lands on word bits [k*PORT_DATAWIDTH +: PORT_DATAWIDTH]; bits past CFG_WIDTH are dropped
    always_comb begin
        for (int i = 0; i < CFG_WIDTH; i++)
            w_word[i] = int'(r_beat) == i / PORT_DATAWIDTH ? bus.rd_data[i % PORT_DATAWIDTH] : r_word[i];
    end
`ifdef CFG_LOADER_CHECK_EN
    assign w_ok = w_word[2:0] >= 3'd1 && w_word[2:0] <= 3'd4 && |w_word;
`else
    assign w_ok = 1'b1;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_REQ;
            S_REQ:   if (bus.rd_req_ready) w_next = S_RECV;
`ifdef CFG_LOADER_CHECK_EN
            S_RECV:  if (w_last) w_next = w_ok ? S_VALID : S_ERR;
`else
            S_RECV:  if (w_last) w_next = S_VALID;
`endif
            S_VALID: if (i_layer_done) w_next = w_done_last ? S_IDLE : S_REQ;
            default: w_next = r_state;
        endcase
    end
    always_comb begin
        bus.rd_req_valid  = r_state == S_REQ;
        bus.rd_req_addr   = r_state == S_REQ ? CFG_BASE + ADDR_WIDTH'(r_layer_idx) * ADDR_WIDTH'(CFG_BEATS * (PORT_DATAWIDTH / 8)) : '0;
        bus.rd_req_len    = 8'(CFG_BEATS - 1);
        bus.rd_data_ready = r_state == S_RECV;
        o_cfg_valid       = r_state == S_VALID;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_layer_idx <= '0;
            r_num_lay   <= '0;
            r_beat      <= '0;
            r_word      <= '0;
            r_all_done  <= 1'b0;
        end else begin
            r_layer_idx <= (r_state == S_IDLE && i_start) || (w_adv && w_done_last) ? '0 :
                           w_adv ? r_layer_idx + 8'd1 : r_layer_idx;
            if (w_beat_acc) begin
                r_word <= w_word;
                r_beat <= w_last ? '0 : r_beat + BW'(1);
            end
            // Layer count is taken only from a layer-0 word that is actually presented
            if (w_last && w_ok && r_layer_idx == 8'd0)
                r_num_lay <= w_word[56:49];
            r_all_done <= w_adv && w_done_last;
        end
    end
`ifdef CFG_LOADER_CHECK_EN
    logic r_err;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_err <= 1'b0;
        else if (w_last && !w_ok)
            r_err <= 1'b1;
    end
    assign o_cfg_err = r_err;
`else
    assign o_cfg_err = 1'b0;
`endif
    assign o_cfg_word      = r_word;
    assign o_cfg_stride    = r_word[2:0];
    assign o_cfg_num_lay   = r_num_lay;
    assign o_cfg_layer_idx = r_layer_idx;
    assign o_all_done      = r_all_done;
endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: randomized self-checking bench for cfg_loader against a slot-array model
module tb_cfg_loader;
    localparam int PDW = 64;
    localparam int AW  = 32;
    localparam int CW  = 82;
`ifdef CFG_LOADER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, layer_done = 1'b0;
    logic          o_cfg_valid, o_all_done, o_cfg_err;
    logic [CW-1:0] o_cfg_word;
    logic [2:0]    o_cfg_stride;
    logic [7:0]    o_cfg_num_lay, o_cfg_layer_idx;
    cfg_loader_if #(.PORT_DATAWIDTH(PDW), .ADDR_WIDTH(AW)) bus ();
    cfg_loader dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_layer_done(layer_done), .bus(bus),
        .o_cfg_valid(o_cfg_valid), .o_cfg_word(o_cfg_word), .o_cfg_stride(o_cfg_stride),
        .o_cfg_num_lay(o_cfg_num_lay), .o_cfg_layer_idx(o_cfg_layer_idx),
        .o_all_done(o_all_done), .o_cfg_err(o_cfg_err)
    );
    always #5 clk = ~clk;
    int            total = 0, bad = 0;
    logic [CW-1:0] words [256];
    int            exp_idx = 0;
    logic [7:0]    exp_nl = 8'd0;
    bit            exp_err = 1'b0, chk_on = 1'b0;
    int            addr_q [$];
    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask
    function automatic logic [CW-1:0] rnd_word(logic [7:0] nlv);
        logic [95:0]   r = {$urandom, $urandom, $urandom};
        logic [CW-1:0] w = r[CW-1:0];
        w[2:0]   = 3'($urandom_range(1, 4));
        w[56:49] = nlv;
        return w;
    endfunction
    function automatic bit word_ok(logic [CW-1:0] w);
        return w[2:0] >= 3'd1 && w[2:0] <= 3'd4 && w != '0;
    endfunction
    // Every cycle: whatever is presented must be the model's slot for the layer being worked on
    always @(negedge clk) begin
        if (chk_on) begin
            if (o_cfg_valid) begin
                check("word", 128'(o_cfg_word), 128'(words[exp_idx]));
                check("stride", 128'(o_cfg_stride), 128'(words[exp_idx][2:0]));
                check("layer_idx", 128'(o_cfg_layer_idx), 128'(exp_idx));
                check("num_lay", 128'(o_cfg_num_lay), 128'(exp_nl));
            end
            if (bus.rd_req_valid) begin
                check("req_addr", 128'(bus.rd_req_addr), 128'(exp_idx * 16));
                check("req_len", 128'(bus.rd_req_len), 128'(1));
            end
            check("err", 128'(o_cfg_err), 128'(exp_err));
            if (exp_err) check("valid_in_err", 128'(o_cfg_valid), 128'(0));
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic serve(int l, int hold, bit abort_after_beat0, output bit ok);
        int             n = 0;
        logic [127:0]   full;
        ok = 1'b0;
        while (!bus.rd_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.rd_req_valid) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got no request want request for layer %0d", l);
            return;
        end
        addr_q.push_back(int'(bus.rd_req_addr));
        repeat (hold) begin
            tick();
            check("req_hold_valid", 128'(bus.rd_req_valid), 128'(1));
        end
        bus.rd_req_ready = 1'b1;
        tick();
        bus.rd_req_ready = 1'b0;
        check("req_dropped", 128'(bus.rd_req_valid), 128'(0));
        full = {46'({$urandom, $urandom}), words[l]};
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 3)) begin
                layer_done = 1'($urandom_range(0, 1));
                tick();
                layer_done = 1'b0;
                check("idx_in_recv", 128'(o_cfg_layer_idx), 128'(l));
                check("valid_in_recv", 128'(o_cfg_valid), 128'(0));
            end
            bus.rd_data       = full[k*64 +: 64];
            bus.rd_data_valid = 1'b1;
            if (k == 1) begin
                @(negedge clk);
                check("pre_valid", 128'(o_cfg_valid), 128'(0));
                check("data_ready", 128'(bus.rd_data_ready), 128'(1));
            end
            tick();
            bus.rd_data_valid = 1'b0;
            if (k == 0 && abort_after_beat0) return;
        end
        if (CHK && !word_ok(words[l])) exp_err = 1'b1;
        @(negedge clk);
        check("latency_valid", 128'(o_cfg_valid), 128'(!exp_err));
        check("all_done_low", 128'(o_all_done), 128'(0));
        tick();
        ok = 1'b1;
    endtask
    task automatic finish_layer(int l, bit last);
        bus.rd_data       = 64'({$urandom, $urandom});
        bus.rd_data_valid = 1'b1;
        repeat ($urandom_range(0, 3)) begin
            start = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            check("no_ready_in_valid", 128'(bus.rd_data_ready), 128'(0));
            check("hold_valid", 128'(o_cfg_valid), 128'(1));
        end
        bus.rd_data_valid = 1'b0;
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        if (!last) exp_idx = l + 1;
        check("valid_drop", 128'(o_cfg_valid), 128'(0));
        check("all_done", 128'(o_all_done), 128'(last));
        tick();
        check("all_done_pulse", 128'(o_all_done), 128'(0));
        if (last) begin
            check("idle_no_req", 128'(bus.rd_req_valid), 128'(0));
            check("idle_idx", 128'(o_cfg_layer_idx), 128'(0));
        end
    endtask
    task automatic run_net(int hmax);
        bit ok;
        exp_idx = 0;
        exp_nl  = words[0][56:49];
        addr_q.delete();
        pulse_start();
        for (int l = 0; l <= int'(exp_nl); l++) begin
            serve(l, $urandom_range(0, hmax), 1'b0, ok);
            if (!ok) return;
            finish_layer(l, l == int'(exp_nl));
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bit ok;
        logic [CW-1:0] w;
        int exp_a [3] = '{0, 16, 32};
        bus.rd_req_ready  = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(o_cfg_valid), 128'(0));
        check("rst_word", 128'(o_cfg_word), 128'(0));
        check("rst_num_lay", 128'(o_cfg_num_lay), 128'(0));
        check("rst_idx", 128'(o_cfg_layer_idx), 128'(0));
        check("rst_all_done", 128'(o_all_done), 128'(0));
        check("rst_err", 128'(o_cfg_err), 128'(0));
        check("rst_req_valid", 128'(bus.rd_req_valid), 128'(0));
        check("rst_data_ready", 128'(bus.rd_data_ready), 128'(0));
        rst_n = 1'b1;
        tick();
        chk_on = 1'b1;
        // single layer, request held off for 5 cycles
        words[0] = 82'h2_ABCD_0001_2345_6789_ABC2;
        exp_idx  = 0;
        exp_nl   = 8'd0;
        addr_q.delete();
        pulse_start();
        check("t1_addr", 128'(bus.rd_req_addr), 128'(32'h0));
        check("t1_len", 128'(bus.rd_req_len), 128'(8'd1));
        serve(0, 5, 1'b0, ok);
        check("t1_word", 128'(o_cfg_word), 128'(82'h2_ABCD_0001_2345_6789_ABC2));
        check("t1_stride", 128'(o_cfg_stride), 128'(3'd2));
        check("t1_num_lay", 128'(o_cfg_num_lay), 128'(8'd0));
        finish_layer(0, 1'b1);
        // three layers
        words[0] = rnd_word(8'd2);
        words[1] = rnd_word(8'($urandom));
        words[2] = rnd_word(8'($urandom));
        run_net(3);
        check("t2_nreq", 128'(addr_q.size()), 128'(3));
        for (int i = 0; i < 3 && i < addr_q.size(); i++)
            check("t2_addr", 128'(addr_q[i]), 128'(exp_a[i]));
        // reset mid-RECV after beat 0
        words[0] = rnd_word(8'd0);
        exp_idx  = 0;
        pulse_start();
        serve(0, 0, 1'b1, ok);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 128'(o_cfg_valid), 128'(0));
        check("mr_word", 128'(o_cfg_word), 128'(0));
        check("mr_num_lay", 128'(o_cfg_num_lay), 128'(0));
        check("mr_idx", 128'(o_cfg_layer_idx), 128'(0));
        check("mr_data_ready", 128'(bus.rd_data_ready), 128'(0));
        check("mr_req_valid", 128'(bus.rd_req_valid), 128'(0));
        tick();
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            check("mr_no_reissue", 128'(bus.rd_req_valid), 128'(0));
        end
        words[0] = rnd_word(8'd1);
        words[1] = rnd_word(8'($urandom));
        run_net(2);
        check("mr_refetch_addr0", 128'(addr_q.size() > 0 ? addr_q[0] : -1), 128'(0));
        // stride-0 word
        w        = rnd_word(8'd0);
        w[2:0]   = 3'd0;
        words[0] = w;
        exp_idx  = 0;
        exp_nl   = 8'd0;
        pulse_start();
        serve(0, 0, 1'b0, ok);
        if (CHK) begin
            layer_done = 1'b1;
            tick();
            layer_done = 1'b0;
            repeat (3) begin
                tick();
                check("err_sticky", 128'(o_cfg_err), 128'(1));
                check("err_no_req", 128'(bus.rd_req_valid), 128'(0));
            end
            rst_n   = 1'b0;
            exp_err = 1'b0;
            tick();
            rst_n = 1'b1;
            tick();
        end else begin
            check("s0_err", 128'(o_cfg_err), 128'(0));
            finish_layer(0, 1'b1);
        end
        // random networks
        repeat (6) begin
            words[0] = rnd_word(8'($urandom_range(0, 7)));
            for (int i = 1; i < 8; i++) words[i] = rnd_word(8'($urandom));
            run_net(5);
        end
        // 256 layers, index runs to 255 without wrapping
        words[0] = rnd_word(8'd255);
        for (int i = 1; i < 256; i++) words[i] = rnd_word(8'($urandom));
        run_net(1);
        check("t256_nreq", 128'(addr_q.size()), 128'(256));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Fetches per-layer configuration words from DDR through a memory-controller read port and assembles them.
- Holds each assembled word stable for the layer-sequencing logic until that layer completes.
- Sits directly downstream of the DDR image: the config area at CFG_BASE holds one fixed-size slot per layer, up to 256 layers.
- Steps through the slots layer by layer and signals the end of the network.

Parameters:
- PORT_DATAWIDTH, 64, width of one read-data beat in bits.
- ADDR_WIDTH, 32, byte-address width of the read-request port.
- CFG_WIDTH, 82, meaningful config bits per layer; packed LSB-first across beats.
- CFG_BEATS, 2, beats per layer slot; must satisfy CFG_BEATS*PORT_DATAWIDTH >= CFG_WIDTH.
- CFG_BASE, 32'h0000_0000, byte address of the layer-0 slot.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins at layer 0. Ignored unless IDLE.
- layer_done  in  1  one-cycle pulse; current layer finished. Ignored unless VALID.
- rd_req_valid  out  1  read-request valid.
- rd_req_ready  in  1  read-request accepted.
- rd_req_addr  out  ADDR_WIDTH  byte address of the slot's first beat.
- rd_req_len  out  8  beats requested; constant CFG_BEATS-1 (AXI-style length).
- rd_data_valid  in  1  read beat valid.
- rd_data_ready  out  1  read beat accepted.
- rd_data  in  PORT_DATAWIDTH  read beat.
- cfg_valid  out  1  cfg_word valid for the current layer.
- cfg_word  out  CFG_WIDTH  assembled config word.
- cfg_stride  out  3  cfg_word[2:0].
- cfg_num_lay  out  8  layer count minus one, latched from the layer-0 word bits [56:49].
- cfg_layer_idx  out  8  index of the current layer.
- all_done  out  1  one-cycle pulse after the final layer_done.
- cfg_err  out  1  sanity-check failure, sticky.

Behaviour:
- Reset: all outputs 0; state IDLE; layer index 0; beat counter 0.
- State IDLE: on start, go to REQ; clear layer index.
- State REQ:
  - rd_req_valid=1, rd_req_addr = CFG_BASE + layer_idx*CFG_BEATS*(PORT_DATAWIDTH/8).
  - Address and valid stay stable until rd_req_ready; go to RECV in the cycle after the handshake.
- State RECV:
  - rd_data_ready=1.
  - Each accepted beat k (0..CFG_BEATS-1) is written to assembly bits [k*PORT_DATAWIDTH +: PORT_DATAWIDTH].
  - Bits beyond CFG_WIDTH are discarded.
  - On the last beat, go to VALID.
- State VALID:
  - cfg_valid=1 from the first VALID cycle. Latency from the last beat's handshake to cfg_valid is exactly 1 cycle.
  - cfg_word is registered and unchanged while in VALID.
  - When layer_idx==0, cfg_num_lay is loaded from the word in the same cycle cfg_valid rises.
- On layer_done in VALID, cfg_valid drops the next cycle, then:
  - If layer_idx==cfg_num_lay: pulse all_done for 1 cycle, go to IDLE, reset layer_idx to 0.
  - Otherwise: increment layer_idx and go to REQ.
- Layer count: cfg_num_lay=0 gives 1 layer; 255 gives 256 layers. The layer index never wraps.
- Simultaneous events:
  - start during a non-IDLE state is ignored.
  - layer_done outside VALID is ignored.
  - An rd_data_valid beat is never accepted outside RECV.
- Reset mid-operation: returns immediately to IDLE; the in-flight read is abandoned and no request is reissued.
- rd_data_valid may deassert between beats; the beat counter holds.

Optional Feature:
- Macro: CFG_LOADER_CHECK_EN.
- When defined, in the first VALID cycle the word is checked:
  - cfg_stride must be in 1..4.
  - Bits [CFG_WIDTH-1:0] must not be all zero.
- On failure:
  - cfg_err=1 (sticky until reset); cfg_valid stays 0.
  - State goes to ERR; only rst_n exits ERR.
- When not defined:
  - cfg_err is tied 0 and the ERR state is absent.
  - Any word is presented unchecked.

Test Plan:
- Single layer: layer-0 word with [56:49]=0 and stride=2, delivered as 2 beats. Required:
  - rd_req_addr=CFG_BASE, rd_req_len=1.
  - cfg_valid 1 cycle after the second beat, cfg_word correct, cfg_stride=2.
  - layer_done -> all_done pulse, back to IDLE.
- Three layers (cfg_num_lay=2), PORT_DATAWIDTH=64:
  - Request addresses are CFG_BASE+0, +16, +32.
  - cfg_layer_idx reads 0, 1, 2.
  - all_done follows only the third layer_done.
- Backpressure:
  - Hold rd_req_ready=0 for 5 cycles -> address and valid stable.
  - Insert a 3-cycle gap between beats -> word still assembled correctly, no extra beat consumed.
- Ignored pulses:
  - start while in VALID -> no effect.
  - layer_done while in RECV -> no effect, layer index unchanged.
- Reset mid-RECV after beat 0 -> all outputs 0, IDLE. A later start fetches layer 0 cleanly.
- With CFG_LOADER_CHECK_EN:
  - Stride=0 word -> cfg_err=1, cfg_valid never asserts, layer_done ignored.
  - Without the macro, the same word -> cfg_valid=1, cfg_err=0.
